// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Definitions shared by the data-memory arbiter and its winner selector.
//   DEF_AW / DEF_DW : default address and data widths
//   IDX_W / idx_t   : requester index type (two requesters -> one bit)
//   state_t         : arbiter FSM states
//   idx_to_onehot   : decodes a requester index into per-requester enables
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int IDX_W  = 1;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic [1:0] idx_to_onehot(input idx_t idx);
        return (idx == idx_t'(0)) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input winner selector. A lone request wins outright; on a tie the
// requester that was NOT granted last wins. Fixed priority is obtained by
// the parent tying i_last to 1, which makes requester 0 win every tie.
// Ports:
//   i_req0, i_req1 : request lines
//   i_last         : index granted most recently
//   o_valid        : at least one request present
//   o_idx          : winning requester index (0 when no request)
// ---------------------------------------------------------------------------
module rr_arb2
    import dmem_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  idx_t i_last,
    output logic o_valid,
    output idx_t o_idx
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_idx   = idx_t'(0);
        if (i_req0 && i_req1) begin
            o_idx = (i_last == idx_t'(1)) ? idx_t'(0) : idx_t'(1);
        end else if (i_req1) begin
            o_idx = idx_t'(1);
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares one single-port data memory between two requesters. An access is
// latched in IDLE, driven to the memory for one cycle in ISSUE, and, for a
// read, returned in RESP using the memory's registered read data.
//   Write: req sampled -> ack one cycle later (latency 2).
//   Read : req sampled -> mem_re next cycle -> ack + rdata (latency 3).
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting; samples req0/req1 and latches the winner
//   ST_ISSUE | drives mem_we (ack same cycle) or mem_re for the access
//   ST_RESP  | returns mem_rdata on rdata with the ack pulse
//
// Build option:
//   DATA_MEM_ARB_FIXED_PRIO_EN defined   -> req0 always wins ties, no
//                                           last-grant register.
//   DATA_MEM_ARB_FIXED_PRIO_EN undefined -> round-robin on ties.
//
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   req0/1, we0/1             : access request, 1 = write / 0 = read
//   addr0/1, wdata0/1         : word address and write data per requester
//   ack0/1                    : one-cycle completion pulses
//   rdata                     : read data, non-zero only in the read ack cycle
//   mem_we, mem_re            : data-memory write / read strobes
//   mem_addr, mem_wdata       : data-memory address / write data
//   mem_rdata                 : registered memory read data
// ---------------------------------------------------------------------------
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,

    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,

    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        r_state;
    state_t        w_state_nxt;

    idx_t          r_idx;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic          w_gnt_valid;
    idx_t          w_gnt_idx;
    idx_t          w_last;
    logic          w_latch;
    logic          w_sel1;
    logic          w_ack;
    logic [1:0]    w_ack_sel;

    // An access is captured only from IDLE; requests arriving in the ack
    // cycle are therefore seen one cycle later, once back in IDLE.
    assign w_latch = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_sel1  = (w_gnt_idx == idx_t'(1));

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    // Presenting "1 was last" permanently makes requester 0 win every tie.
    assign w_last = idx_t'(1);
`else
    idx_t r_last;

    // Reset value 1 gives requester 0 the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= idx_t'(1);
        end else if (w_latch) begin
            r_last <= w_gnt_idx;
        end
    end

    assign w_last = r_last;
`endif

    rr_arb2 u_rr_arb2 (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_last  (w_last),
        .o_valid (w_gnt_valid),
        .o_idx   (w_gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= idx_t'(0);
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_idx   <= w_gnt_idx;
                r_we    <= w_sel1 ? we1    : we0;
                r_addr  <= w_sel1 ? addr1  : addr0;
                r_wdata <= w_sel1 ? wdata1 : wdata0;
            end
        end
    end

    // Memory-side outputs are zero except in ISSUE, rdata except in RESP.
    always_comb begin
        w_state_nxt = r_state;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        rdata       = '0;
        w_ack       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_addr = r_addr;
                if (r_we) begin
                    mem_we      = 1'b1;
                    mem_wdata   = r_wdata;
                    w_ack       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    mem_re      = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rdata       = mem_rdata;
                w_ack       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A single latched index steers the one ack, so both can never fire.
    assign w_ack_sel = idx_to_onehot(r_idx);
    assign ack0      = w_ack & w_ack_sel[0];
    assign ack1      = w_ack & w_ack_sel[1];

endmodule
